piso_multilane: RTL and testbench
=================================

PISO_MULTILANE -- requirements
Module: piso_multilane

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning parallel input word width in bits.
REQ-002 SHALL have parameter LANES, default 1, meaning bits emitted per output beat.
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning beat order (0: LSB first; 1: MSB first).
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din_valid  input  1  input word valid.
REQ-007 SHALL have port din_ready  output  1  input word accepted when din_valid & din_ready.
REQ-008 SHALL have port din_data  input  DATAWIDTH  parallel word.
REQ-009 SHALL have port dout_valid  output  1  output beat valid.
REQ-010 SHALL have port dout_ready  input  1  beat consumed when dout_valid & dout_ready.
REQ-011 SHALL have port dout_data  output  LANES (2*LANES with PISO_DUAL_RAIL_EN)  beat payload.
REQ-012 SHALL have port dout_last  output  1  high on the final beat of a word.

Function
REQ-013 SHALL emit N = DATAWIDTH/LANES beats per accepted word; an elaboration error SHALL fire if LANES < 1 or DATAWIDTH % LANES != 0.
REQ-014 SHALL contain a shifter (states IDLE, SHIFT), beat counter cnt (0..N-1) and a one-entry hold register with flag hold_valid.
REQ-015 SHALL drive din_ready = ~hold_valid, with no combinational path from dout_ready.
REQ-016 "Shifter free" SHALL mean state IDLE, or state SHIFT with cnt == N-1 and the beat handshaking this edge.
REQ-017 On a din handshake: if the shifter is free and hold is empty, the word SHALL load the shifter directly; otherwise it SHALL load hold.
REQ-018 If the shifter is free and hold_valid is set, hold SHALL move into the shifter; a simultaneous din handshake SHALL refill hold in the same edge.
REQ-019 A loaded shifter SHALL enter SHIFT with cnt = 0; dout_valid SHALL be registered and high exactly in SHIFT, so the first beat appears the cycle after load.
REQ-020 Beat k SHALL carry word[k*LANES +: LANES] if MSB_FIRST = 0, else word[DATAWIDTH-1-k*LANES -: LANES].
REQ-021 On each dout handshake cnt SHALL increment; at cnt == N-1 the shifter SHALL reload per REQ-017/018 or return to IDLE.
REQ-022 dout_last SHALL equal dout_valid & (cnt == N-1).
REQ-023 While dout_valid & ~dout_ready, dout_data and dout_last SHALL hold stable.
REQ-024 With dout_ready continuously high and words offered continuously, beats SHALL be back-to-back, with no idle cycle between words.
REQ-025 In IDLE, dout_data SHALL be all zeros.

Reset
REQ-026 While rst_n is low: state IDLE, cnt 0, hold_valid 0, dout_valid 0, dout_last 0, dout_data 0; din_ready therefore reads 1.
REQ-027 Assertion mid-word SHALL discard the shifter and hold contents; after release the next accepted word SHALL start at beat 0.

Configuration
REQ-028 With macro PISO_DUAL_RAIL_EN defined, each lane i SHALL output dout_data[2i] = b & dout_valid and dout_data[2i+1] = ~b & dout_valid; the output is 2*LANES wide.
REQ-029 Without PISO_DUAL_RAIL_EN, dout_data SHALL be LANES wide and carry the lane bits directly.

Structure
REQ-030 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and a constant function beats(DATAWIDTH, LANES).
REQ-031 The hold register SHALL be a sub-module piso_hold_reg (one-entry buffer with valid flag).

Verification
REQ-032 DATAWIDTH=8, LANES=1, LSB first, din 0xA5, dout_ready=1 -> beats 1,0,1,0,0,1,0,1 starting the cycle after accept; dout_last only on beat 8.
REQ-033 LANES=2, MSB_FIRST=1, din 0xB4 -> beats 2'b10, 2'b11, 2'b01, 2'b00; dout_last on the 4th beat.
REQ-034 Words 0x01 then 0x80 offered back-to-back, dout_ready=1 -> 16 consecutive valid beats with no bubble; din_ready low while hold is full.
REQ-035 dout_ready toggling every cycle on din 0x3C -> beat data stable across stalls; all 8 beats delivered in order with none lost.
REQ-036 rst_n pulsed low after 3 beats of 0xFF, with 0x0F held -> dout_valid 0 during reset; next word 0x55 emits from beat 0.
REQ-037 With PISO_DUAL_RAIL_EN, LANES=1 -> bit 1 gives dout_data 2'b01, bit 0 gives 2'b10, IDLE gives 2'b00.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the multilane PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Beats per word; a zero lane count is guarded so elaboration can report it cleanly.
  function automatic int beats(input int dw, input int lanes);
    return (lanes < 1) ? 1 : dw / lanes;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry word buffer with valid flag; a load wins over a simultaneous take (refill).
module piso_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_multilane.sv
// Parallel-in, serial-out with LANES bits per beat and a one-word hold buffer.
// Optional macro PISO_DUAL_RAIL_EN: each lane is emitted as a (b, ~b) pair gated by dout_valid.
module piso_multilane
  import piso_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [DATAWIDTH-1:0] din_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
`ifdef PISO_DUAL_RAIL_EN
  output logic [2*LANES-1:0]   dout_data,
`else
  output logic [LANES-1:0]     dout_data,
`endif
  output logic                 dout_last
);

  localparam int N     = beats(DATAWIDTH, LANES);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((LANES < 1) ? 1'b1 : (DATAWIDTH % LANES != 0)) begin : g_cfg_err
      $error("piso_multilane: LANES must be >= 1 and divide DATAWIDTH");
    end
  endgenerate

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [DATAWIDTH-1:0]   shreg, shreg_nx, shreg_adv;
  logic [LANES-1:0]       beat;
  logic                   hold_valid, hold_load, hold_take;
  logic [DATAWIDTH-1:0]   hold_data;
  logic                   din_hs, beat_hs, free;

  piso_hold_reg #(.WIDTH(DATAWIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .take      (hold_take),
    .load_data (din_data),
    .valid     (hold_valid),
    .data      (hold_data)
  );

  assign din_ready  = ~hold_valid;
  assign din_hs     = din_valid & din_ready;
  assign dout_valid = (state == SHIFT);
  assign beat_hs    = dout_valid & dout_ready;
  assign free       = (state == IDLE) | (beat_hs & (cnt == LAST));

  // The current beat always sits at the exit end of the shift register.
  assign shreg_adv = (MSB_FIRST != 0) ? (shreg << LANES) : (shreg >> LANES);
  assign beat      = (MSB_FIRST != 0) ? shreg[DATAWIDTH-1 -: LANES] : shreg[LANES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shreg_nx  = shreg;
    hold_load = 1'b0;
    hold_take = 1'b0;
    if (free) begin
      cnt_nx = '0;
      if (hold_valid) begin
        shreg_nx  = hold_data;
        hold_take = 1'b1;
        hold_load = din_hs;
        state_nx  = SHIFT;
      end else if (din_hs) begin
        shreg_nx = din_data;
        state_nx = SHIFT;
      end else begin
        state_nx = IDLE;
      end
    end else begin
      hold_load = din_hs;
      if (beat_hs) begin
        cnt_nx   = cnt + CNT_W'(1);
        shreg_nx = shreg_adv;
      end
    end
  end

  assign dout_last = dout_valid & (cnt == LAST);

`ifdef PISO_DUAL_RAIL_EN
  always_comb begin
    dout_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dout_data[2*i]   = beat[i] & dout_valid;
      dout_data[2*i+1] = ~beat[i] & dout_valid;
    end
  end
`else
  assign dout_data = beat & {LANES{dout_valid}};
`endif

endmodule

// File: tb/tb_piso_multilane.sv
// Self-checking bench: two configurations (8x1 LSB-first, 8x2 MSB-first), vector table,
// corner-case sequences and randomized traffic against a beat-queue reference model.
module tb_piso_multilane;

`ifdef PISO_DUAL_RAIL_EN
  localparam int DR = 2;
`else
  localparam int DR = 1;
`endif

  logic clk, rst_n;
  logic v0, r0, ov0, or0, ol0;
  logic [7:0] d0;
  logic [DR-1:0] od0;
  logic v1, r1, ov1, or1, ol1;
  logic [7:0] d1;
  logic [2*DR-1:0] od1;

  int n_chk, n_fail;

  piso_multilane #(.DATAWIDTH(8), .LANES(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din_valid(v0), .din_ready(r0), .din_data(d0),
    .dout_valid(ov0), .dout_ready(or0), .dout_data(od0), .dout_last(ol0));

  piso_multilane #(.DATAWIDTH(8), .LANES(2), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(v1), .din_ready(r1), .din_data(d1),
    .dout_valid(ov1), .dout_ready(or1), .dout_data(od1), .dout_last(ol1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output encoding of a raw beat value.
  function automatic logic [3:0] enc(input logic [1:0] b, input int lanes);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      if (DR == 2) begin
        r[2*i]   = b[i];
        r[2*i+1] = ~b[i];
      end else begin
        r[i] = b[i];
      end
    end
    return r;
  endfunction

  // Reference: beat k of a word, computed straight from the ordering rule.
  function automatic logic [1:0] slice(input logic [7:0] w, input int lanes, input int msb, input int k);
    int sh;
    sh = (msb != 0) ? 8 - (k + 1) * lanes : k * lanes;
    return 2'((w >> sh) & ((1 << lanes) - 1));
  endfunction

  // Beat-queue scoreboards: {last, beat}
  logic [2:0] q0[$], q1[$];
  logic stall0, stall1;
  logic [DR-1:0] pd0;
  logic [2*DR-1:0] pd1;
  logic pl0, pl1;

  always @(negedge clk) begin
    logic [2:0] e;
    logic [3:0] x;
    if (!rst_n) begin
      q0.delete();
      stall0 = 1'b0;
    end else begin
      if (stall0) chk(od0 == pd0 && ol0 == pl0, "stable0", 32'({ol0, od0}), 32'({pl0, pd0}));
      if (ov0 && or0) begin
        if (q0.size() == 0) chk(1'b0, "extra_beat0", 32'(od0), 0);
        else begin
          e = q0.pop_front();
          x = enc(e[1:0], 1);
          chk(od0 == x[DR-1:0] && ol0 == e[2], "beat0", 32'({ol0, od0}), 32'({e[2], x[DR-1:0]}));
        end
      end
      if (!ov0) chk(od0 == '0 && ol0 == 1'b0, "idle0", 32'({ol0, od0}), 0);
      if (v0 && r0)
        for (int k = 0; k < 8; k++) q0.push_back({k == 7, slice(d0, 1, 0, k)});
      stall0 = ov0 && !or0;
      pd0 = od0;
      pl0 = ol0;
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    logic [3:0] x;
    if (!rst_n) begin
      q1.delete();
      stall1 = 1'b0;
    end else begin
      if (stall1) chk(od1 == pd1 && ol1 == pl1, "stable1", 32'({ol1, od1}), 32'({pl1, pd1}));
      if (ov1 && or1) begin
        if (q1.size() == 0) chk(1'b0, "extra_beat1", 32'(od1), 0);
        else begin
          e = q1.pop_front();
          x = enc(e[1:0], 2);
          chk(od1 == x[2*DR-1:0] && ol1 == e[2], "beat1", 32'({ol1, od1}), 32'({e[2], x[2*DR-1:0]}));
        end
      end
      if (!ov1) chk(od1 == '0 && ol1 == 1'b0, "idle1", 32'({ol1, od1}), 0);
      if (v1 && r1)
        for (int k = 0; k < 4; k++) q1.push_back({k == 3, slice(d1, 2, 1, k)});
      stall1 = ov1 && !or1;
      pd1 = od1;
      pl1 = ol1;
    end
  end

  typedef struct {
    bit         sel1;
    logic [7:0] din;
    logic [1:0] exp [8];
    int         n;
  } vec_t;

  vec_t tbl[7];

  // Drive one word on an idle DUT with dout_ready high; check latency, beats, dout_last, and return to idle.
  task automatic run_word(input int idx);
    logic [3:0] x;
    bit s;
    s = tbl[idx].sel1;
    @(posedge clk); #1;
    if (s) begin v1 = 1'b1; d1 = tbl[idx].din; or1 = 1'b1; end
    else   begin v0 = 1'b1; d0 = tbl[idx].din; or0 = 1'b1; end
    @(negedge clk);
    chk(s ? r1 : r0, "vec_din_ready", 32'(s ? r1 : r0), 1);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    for (int k = 0; k < tbl[idx].n; k++) begin
      @(negedge clk);
      x = enc(tbl[idx].exp[k], s ? 2 : 1);
      if (s) chk(ov1 && od1 == x[2*DR-1:0] && ol1 == (k == tbl[idx].n - 1), "vec_beat",
                 32'({ov1, ol1, od1}), 32'({1'b1, k == tbl[idx].n - 1, x[2*DR-1:0]}));
      else   chk(ov0 && od0 == x[DR-1:0] && ol0 == (k == tbl[idx].n - 1), "vec_beat",
                 32'({ov0, ol0, od0}), 32'({1'b1, k == tbl[idx].n - 1, x[DR-1:0]}));
    end
    @(negedge clk);
    chk(!(s ? ov1 : ov0), "vec_end_idle", 32'(s ? ov1 : ov0), 0);
  endtask

  initial begin
    int got;
    bit bubble;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    v0 = 0; d0 = 0; or0 = 0; v1 = 0; d1 = 0; or1 = 0;

    tbl[0] = '{sel1: 1'b0, din: 8'hA5, exp: '{1, 0, 1, 0, 0, 1, 0, 1}, n: 8};
    tbl[1] = '{sel1: 1'b0, din: 8'h3C, exp: '{0, 0, 1, 1, 1, 1, 0, 0}, n: 8};
    tbl[2] = '{sel1: 1'b1, din: 8'hB4, exp: '{2, 3, 1, 0, 0, 0, 0, 0}, n: 4};
    tbl[3] = '{sel1: 1'b1, din: 8'h1B, exp: '{0, 1, 2, 3, 0, 0, 0, 0}, n: 4};
    tbl[4] = '{sel1: 1'b1, din: 8'hE4, exp: '{3, 2, 1, 0, 0, 0, 0, 0}, n: 4};
    tbl[5] = '{sel1: 1'b0, din: 8'h55, exp: '{1, 0, 1, 0, 1, 0, 1, 0}, n: 8};
    tbl[6] = '{sel1: 1'b0, din: 8'h80, exp: '{0, 0, 0, 0, 0, 0, 0, 1}, n: 8};

    #2;
    chk(!ov0 && !ol0 && od0 == '0 && r0, "reset0", 32'({ov0, ol0, r0}), 32'(3'b001));
    chk(!ov1 && !ol1 && od1 == '0 && r1, "reset1", 32'({ov1, ol1, r1}), 32'(3'b001));
    #20 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_word(i);

    // Two words back-to-back: 16 gapless beats, din_ready low while hold is occupied.
    @(posedge clk); #1;
    or0 = 1'b1; v0 = 1'b1; d0 = 8'h01;
    @(posedge clk); #1;
    d0 = 8'h80;
    bubble = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!ov0) bubble = 1'b1;
      if (i == 0) chk(r0, "b2b_ready_first", 32'(r0), 1);
      if (i >= 1 && i <= 7) chk(!r0, "b2b_hold_full", 32'(r0), 0);
      @(posedge clk); #1;
      if (i == 0) v0 = 1'b0;
    end
    chk(!bubble, "b2b_no_bubble", 32'(bubble), 0);
    @(negedge clk);
    chk(!ov0 && r0 && q0.size() == 0, "b2b_end", 32'({ov0, r0}), 32'(2'b01));

    // Stalls: dout_ready toggling every cycle.
    @(posedge clk); #1;
    v0 = 1'b1; d0 = 8'h3C; or0 = 1'b0;
    @(posedge clk); #1;
    v0 = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got < 8; i++) begin
      @(negedge clk);
      if (ov0 && or0) got++;
      @(posedge clk); #1;
      or0 = ~or0;
    end
    or0 = 1'b1;
    chk(got == 8, "stall_count", 32'(got), 8);
    @(negedge clk);
    chk(!ov0 && q0.size() == 0, "stall_end", 32'({ov0, q0.size() != 0}), 0);

    // Reset mid-word with a second word waiting in hold.
    @(posedge clk); #1;
    v0 = 1'b1; d0 = 8'hFF;
    @(posedge clk); #1;
    d0 = 8'h0F;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk(!ov0 && !ol0 && od0 == '0 && r0, "midreset", 32'({ov0, ol0, r0}), 32'(3'b001));
    @(posedge clk); #1;
    chk(!ov0 && r0, "midreset_hold", 32'({ov0, r0}), 32'(2'b01));
    rst_n = 1'b1;
    run_word(5);

    // Randomized traffic on both configurations.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      v0 = 1'($urandom); d0 = 8'($urandom); or0 = ($urandom_range(3) != 0);
      v1 = 1'($urandom); d1 = 8'($urandom); or1 = 1'($urandom);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !ov0 && !ov1) begin got = 1; break; end
    end
    chk(got == 1, "drain", 32'({q0.size() != 0, q1.size() != 0}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
